// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the RV32I fetch stage.
// Holds the datapath width, the NOP word and the fetch FSM encodings.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [2:0] ST_BOOT = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter for the fetch stage.
// Redirects win over the sequential +4 step.
module fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_i,
  input  logic        redir_i,
  input  logic [31:0] redir_pc_i,
  output logic [31:0] pc_o
);
  import fetch_unit_pkg::*;

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Select the next PC; the add wraps modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (redir_i) begin
      pc_d = word_align(redir_pc_i);
    end else if (adv_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read,
// holds the returned word until decode accepts it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign
);
  import fetch_unit_pkg::*;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic [31:0] inst_d;
  logic [31:0] ipc_q;
  logic [31:0] ipc_d;
  logic        in_hold;
  logic        fire;
  logic        capture;

  assign in_hold = (state_q == ST_HOLD);
  assign fire    = in_hold & inst_ready & ~redirect_valid;
  assign capture = (state_q == ST_WAIT) & imem_rvalid
                 & ~redirect_valid;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .adv_i      (fire),
    .redir_i    (redirect_valid),
    .redir_pc_i (redirect_pc),
    .pc_o       (pc)
  );

  // Next-state logic; a redirect outranks every other event.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_gnt) begin
          state_d = redirect_valid ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || inst_ready) begin
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (!redirect_valid && imem_rvalid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Capture fetched word; fall back to NOP when HOLD is left.
  always_comb begin
    inst_d = inst_q;
    ipc_d  = ipc_q;
    if (capture) begin
      inst_d = imem_rdata;
      ipc_d  = pc;
    end else if (in_hold && (fire || redirect_valid)) begin
      inst_d = NOP_INST;
    end
  end

  // FSM and holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      inst_q  <= NOP_INST;
      ipc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = pc;
  assign inst_valid = in_hold & ~redirect_valid;
  assign inst       = inst_q;
  assign inst_pc    = ipc_q;
  assign misalign   = redirect_valid & redirect_pc[1];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RV32I core. It owns the program counter, issues one outstanding read at a time to instruction memory, and holds the returned word until decode accepts it. It sits directly upstream of the decoder and immediate generator, and it accepts PC redirects from the branch/jump resolution logic.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.
- NOP_INST, 32'h0000_0013, value driven on `inst` while no instruction is held (`addi x0,x0,0`).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word-aligned read address; equals `pc`.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  taken branch, JAL or JALR; replaces the PC.
- redirect_pc  in  32  target address.
- inst_valid  out  1  `inst` and `inst_pc` are valid for decode.
- inst_ready  in  1  decode accepts the instruction.
- inst  out  32  instruction to decoder and immediate generator.
- inst_pc  out  32  address of `inst`; used by AUIPC, JAL and branch target add.
- misalign  out  1  one-cycle pulse when `redirect_pc[1]` is 1.

## Operation
- States:
  - BOOT: idle for 1 cycle after reset.
  - REQ: `imem_req`=1, waiting for `imem_gnt`.
  - WAIT: granted, waiting for `imem_rvalid`.
  - HOLD: instruction held, waiting for `inst_ready`.
  - DROP: a stale response is in flight and will be discarded.
- State transitions:
  - BOOT→REQ unconditionally.
  - REQ→WAIT on `imem_gnt`.
  - WAIT→HOLD on `imem_rvalid`; capture `inst`←`imem_rdata` and `inst_pc`←`pc`.
  - HOLD→REQ on fire (`inst_valid & inst_ready`); `pc`←`pc`+4.
  - DROP→REQ on `imem_rvalid`; the data is discarded.
- Redirects have priority over every other event in the same cycle. On a redirect, `pc`←{`redirect_pc`[31:2],2'b00}. The next state is:
  - REQ without `imem_gnt`: stay in REQ. `imem_addr` changes only in the cycle after the redirect.
  - REQ with `imem_gnt` in the same cycle: DROP (the granted fetch is stale).
  - WAIT without `imem_rvalid`: DROP.
  - WAIT with `imem_rvalid` in the same cycle: REQ; the data is discarded.
  - HOLD: REQ; the held instruction is killed, even if `inst_ready`=1.
  - DROP: stay in DROP.
  - BOOT: REQ.
- `inst_valid` = (state==HOLD) & ~`redirect_valid`. This combinational kill guarantees decode never consumes an instruction from the wrong path.
- `misalign` pulses only when the redirect is taken and `redirect_pc[1]`=1. `redirect_pc[0]` is silently cleared.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000, with no error.
- `inst` returns to NOP_INST whenever HOLD is left without a fresh capture.

## Timing
- Reset values:
  - state BOOT
  - `pc` = RESET_PC
  - `imem_req` = 0
  - `inst_valid` = 0
  - `inst` = NOP_INST
  - `inst_pc` = RESET_PC
  - `misalign` = 0
- Reset mid-operation aborts everything immediately. A response still in flight after reset is ignored, because BOOT and REQ do not sample `imem_rvalid`.
- Minimum fetch latency: with `imem_gnt` in the request cycle and `imem_rvalid` one cycle later, `inst_valid` rises 2 cycles after REQ is entered.
- Best-case throughput is 1 instruction per 3 cycles (REQ→WAIT→HOLD), which is acceptable for the single-cycle core.
- `imem_req` and `imem_addr` are stable while in REQ until granted, except for the redirect case above.
- At most one read is outstanding. `imem_req` is never asserted in WAIT, HOLD or DROP.

## Structure
- Shared defines header holds:
  - `NOP_INST`
  - the state encodings (3-bit: BOOT, REQ, WAIT, HOLD, DROP)
  - `XLEN` = 32
- One sub-module, `fetch_pc_reg`: a 32-bit PC register with async reset to RESET_PC, a +4 incrementer, and a redirect mux with low-bit masking.
- The state machine, the instruction/inst_pc holding registers and the output gating live in `fetch_unit`.

## Test plan
- Reset, then grant in the first REQ cycle, `imem_rvalid` 1 cycle later with `imem_rdata`=32'h00500093, `inst_ready`=1 → `inst_valid` pulses with `inst`=32'h00500093 and `inst_pc`=0, then the next `imem_addr`=4.
- Hold `inst_ready`=0 for 5 cycles → `inst` and `inst_pc` stay stable, `imem_req` stays 0, and `pc` does not advance.
- In WAIT, redirect to 32'h100 → DROP; the stale `imem_rdata` (32'hDEADBEEF) is never presented; the next `imem_addr`=32'h100.
- In HOLD, assert `redirect_valid` together with `inst_ready` (target 32'h40) → `inst_valid`=0 that cycle and the next fetch is from 32'h40.
- Redirect to 32'h202 → `misalign` pulses once and `imem_addr`=32'h200. Redirect to 32'h201 → no pulse and `imem_addr`=32'h200.
- Starting with `pc`=32'hFFFF_FFFC, consume one instruction → next `imem_addr`=0. Then assert `rst` while in WAIT → all outputs return to their reset values within the same cycle.
